mda_motor_ramp_ctrl: RTL and testbench

MDA_MOTOR_RAMP_CTRL -- requirements
Module: mda_motor_ramp_ctrl

---
 rtl/mda_motor_ramp_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mda_motor_ramp_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mda_motor_ramp_ctrl.sv
// Eight-channel motor duty ramp controller behind an Avalon-MM register file.
// Optional watchdog: define MDA_RAMP_WATCHDOG_EN to build it in.
module mda_motor_ramp_ctrl #(
   parameter int DUTY_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  chipselect,
   input  logic                  write,
   input  logic                  read,
   input  logic [4:0]            addr,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [15:0]           motor_in,
   output logic [8*DUTY_W-1:0]   duty_cycle
);

   // state    | meaning
   // ST_RUN   | duty ramps toward effective target
   // ST_DECEL | direction change requested, duty ramps toward 0
   // ST_SWAP  | duty is 0, applied in bits take the request on the next tick
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DECEL = 2'd1,
      ST_SWAP  = 2'd2
   } ch_state_e;

   logic              wr_en;
   logic              rd_en;
   logic              tick;
   logic [15:0]       tick_cnt_q;
   logic [15:0]       tick_cnt_d;
   logic [15:0]       prescale_q;
   logic [DUTY_W-1:0] step_q;
   logic [DUTY_W-1:0] target_q [8];
   logic [1:0]        req_q    [8];
   logic [DUTY_W-1:0] duty_q   [8];
   logic [1:0]        in_q     [8];
   ch_state_e         state_q  [8];
   logic [DUTY_W-1:0] eff_tgt  [8];
   logic [1:0]        eff_req  [8];
   logic [DUTY_W-1:0] run_duty [8];
   logic [DUTY_W-1:0] dec_duty [8];
   logic [7:0]        busy;
   logic              wd_trip;
   logic [15:0]       wd_timeout;
   logic [31:0]       rd_val;
   logic [31:0]       readdata_q;

   assign wr_en = chipselect & write;
   assign rd_en = chipselect & read;

   // The >= compare lets a prescale lowered below the running count tick at once.
   assign tick       = (tick_cnt_q >= prescale_q);
   assign tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;

   function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] cur,
                                              input logic [DUTY_W-1:0] tgt,
                                              input logic [DUTY_W-1:0] stp);
      logic [DUTY_W-1:0] diff;
      if (cur < tgt) begin
         diff = tgt - cur;
         return (diff <= stp) ? tgt : cur + stp;
      end
      diff = cur - tgt;
      return (diff <= stp) ? tgt : cur - stp;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            target_q[i] <= '0;
            req_q[i]    <= '0;
         end
         prescale_q <= '0;
         step_q     <= '0;
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         if (wr_en) begin
            case (addr[4:3])
               2'd0: target_q[addr[2:0]] <= writedata[DUTY_W-1:0];
               2'd1: req_q[addr[2:0]]    <= writedata[1:0];
               2'd2: begin
                  if (addr[2:0] == 3'd0) prescale_q <= writedata[15:0];
                  if (addr[2:0] == 3'd1) step_q     <= writedata[DUTY_W-1:0];
               end
               default: ;
            endcase
         end
      end
   end

`ifdef MDA_RAMP_WATCHDOG_EN
   logic [15:0] wd_timeout_q;
   logic [15:0] wd_cnt_q;
   logic [15:0] wd_cnt_d;
   logic        wd_trip_q;
   logic        wd_trip_d;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (wr_en)
         wd_cnt_d = 16'd0;
      else if (tick && wd_cnt_q != 16'hFFFF)
         wd_cnt_d = wd_cnt_q + 16'd1;
      wd_trip_d = wd_trip_q;
      if (wr_en && addr == 5'd19)
         wd_trip_d = 1'b0;
      else if (wd_timeout_q != 16'd0 && wd_cnt_q >= wd_timeout_q)
         wd_trip_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_timeout_q <= '0;
         wd_cnt_q     <= '0;
         wd_trip_q    <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         wd_trip_q <= wd_trip_d;
         if (wr_en && addr == 5'd18)
            wd_timeout_q <= writedata[15:0];
      end
   end

   assign wd_trip    = wd_trip_q;
   assign wd_timeout = wd_timeout_q;
`else
   assign wd_trip    = 1'b0;
   assign wd_timeout = 16'd0;
`endif

   // A tripped watchdog forces every channel to stop and drop its in bits.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         eff_tgt[i]  = wd_trip ? {DUTY_W{1'b0}} : target_q[i];
         eff_req[i]  = wd_trip ? 2'b00 : req_q[i];
         run_duty[i] = ramp(duty_q[i], eff_tgt[i], step_q);
         dec_duty[i] = ramp(duty_q[i], {DUTY_W{1'b0}}, step_q);
         busy[i]     = (duty_q[i] != eff_tgt[i]) || (eff_req[i] != in_q[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            state_q[i] <= ST_RUN;
            duty_q[i]  <= '0;
            in_q[i]    <= '0;
         end
      end else if (tick) begin
         for (int i = 0; i < 8; i++) begin
            case (state_q[i])
               ST_RUN, ST_DECEL: begin
                  if (eff_req[i] != in_q[i]) begin
                     duty_q[i]  <= dec_duty[i];
                     state_q[i] <= (dec_duty[i] == '0) ? ST_SWAP : ST_DECEL;
                  end else begin
                     duty_q[i]  <= run_duty[i];
                     state_q[i] <= ST_RUN;
                  end
               end
               ST_SWAP: begin
                  in_q[i]    <= eff_req[i];
                  state_q[i] <= ST_RUN;
               end
               default: state_q[i] <= ST_RUN;
            endcase
         end
      end
   end

   always_comb begin
      rd_val = 32'd0;
      case (addr[4:3])
         2'd0: rd_val = 32'(duty_q[addr[2:0]]);
         2'd1: rd_val = {30'd0, in_q[addr[2:0]]};
         2'd2: begin
            case (addr[2:0])
               3'd0:    rd_val = {16'd0, prescale_q};
               3'd1:    rd_val = 32'(step_q);
               3'd2:    rd_val = {16'd0, wd_timeout};
               3'd3:    rd_val = {23'd0, wd_trip, busy};
               default: rd_val = 32'd0;
            endcase
         end
         default: rd_val = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         readdata_q <= '0;
      else if (rd_en)
         readdata_q <= rd_val;
   end

   assign readdata = readdata_q;

   for (genvar g = 0; g < 8; g++) begin : g_out
      assign duty_cycle[g*DUTY_W +: DUTY_W] = duty_q[g];
      assign motor_in[2*g +: 2]             = in_q[g];
   end

endmodule

// File: tb/tb_mda_motor_ramp_ctrl.sv
// Self-checking bench for mda_motor_ramp_ctrl: directed ramp/swap/prescale/reset
// scenarios plus randomized register traffic against a behavioural model.
module tb_mda_motor_ramp_ctrl;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cs = 1'b0;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic [4:0]    addr = '0;
   logic [31:0]   wdata = '0;
   logic [31:0]   readdata;
   logic [15:0]   motor_in;
   logic [127:0]  duty_cycle;

   int n_checks = 0;
   int n_errors = 0;

   mda_motor_ramp_ctrl #(.DUTY_W(16)) dut (
      .clk(clk), .reset(reset), .chipselect(cs), .write(wr), .read(rd),
      .addr(addr), .writedata(wdata), .readdata(readdata),
      .motor_in(motor_in), .duty_cycle(duty_cycle)
   );

   always #5 clk = ~clk;

   // Behavioural model: plain integers; a channel is either ramping (toward target,
   // or toward 0 while its request differs) or waiting one tick to swap in bits.
   int m_tgt[8], m_req[8], m_duty[8], m_in[8];
   bit m_pend[8];
   int m_pre, m_stp, m_wdto, m_wcnt, m_tcnt;
   bit m_trip;
   logic [31:0] m_rdata;

   function automatic int toward(input int cur, input int tgt, input int stp);
      if (cur < tgt) return (tgt - cur <= stp) ? tgt : cur + stp;
      if (cur > tgt) return (cur - tgt <= stp) ? tgt : cur - stp;
      return cur;
   endfunction

   function automatic int eff_t(input int i);
      return m_trip ? 0 : m_tgt[i];
   endfunction

   function automatic int eff_r(input int i);
      return m_trip ? 0 : m_req[i];
   endfunction

   function automatic logic [31:0] m_read(input int a);
      int b;
      b = 0;
      if (a < 8) return 32'(m_duty[a]);
      if (a < 16) return 32'(m_in[a-8]);
      case (a)
         16: return 32'(m_pre);
         17: return 32'(m_stp);
         18: return 32'(m_wdto);
         19: begin
            for (int i = 0; i < 8; i++)
               if (m_duty[i] != eff_t(i) || eff_r(i) != m_in[i]) b = b | (1 << i);
            return 32'((int'(m_trip) << 8) | b);
         end
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 8; i++) begin
         m_tgt[i] = 0; m_req[i] = 0; m_duty[i] = 0; m_in[i] = 0; m_pend[i] = 0;
      end
      m_pre = 0; m_stp = 0; m_wdto = 0; m_wcnt = 0; m_tcnt = 0;
      m_trip = 0; m_rdata = '0;
   endtask

   task automatic m_clock();
      bit w, r, tk;
      int a, d;
      w  = cs & wr;
      r  = cs & rd;
      a  = int'(addr);
      d  = int'(wdata);
      tk = (m_tcnt >= m_pre);
      if (r) m_rdata = m_read(a);
      if (tk) begin
         for (int i = 0; i < 8; i++) begin
            if (m_pend[i]) begin
               m_in[i]   = eff_r(i);
               m_pend[i] = 0;
            end else if (eff_r(i) != m_in[i]) begin
               m_duty[i] = toward(m_duty[i], 0, m_stp);
               if (m_duty[i] == 0) m_pend[i] = 1;
            end else begin
               m_duty[i] = toward(m_duty[i], eff_t(i), m_stp);
            end
         end
      end
      m_tcnt = tk ? 0 : m_tcnt + 1;
`ifdef MDA_RAMP_WATCHDOG_EN
      if (w && a == 19) m_trip = 0;
      else if (m_wdto != 0 && m_wcnt >= m_wdto) m_trip = 1;
      if (w) m_wcnt = 0;
      else if (tk && m_wcnt < 65535) m_wcnt = m_wcnt + 1;
`endif
      if (w) begin
         if (a < 8) m_tgt[a] = d & 32'hFFFF;
         else if (a < 16) m_req[a-8] = d & 3;
         else if (a == 16) m_pre = d & 32'hFFFF;
         else if (a == 17) m_stp = d & 32'hFFFF;
`ifdef MDA_RAMP_WATCHDOG_EN
         else if (a == 18) m_wdto = d & 32'hFFFF;
`endif
      end
   endtask

   function automatic logic [127:0] m_duty_vec();
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'(m_duty[i]);
      return v;
   endfunction

   function automatic logic [127:0] m_in_vec();
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[i*2 +: 2] = 2'(m_in[i]);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) m_reset();
         else m_clock();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("duty_cycle", duty_cycle, m_duty_vec());
            chk("motor_in", 128'(motor_in), m_in_vec());
            chk("readdata", 128'(readdata), 128'(m_rdata));
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timed out");
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic bus_wr(input int a, input int d);
      cs = 1; wr = 1; rd = 0; addr = a[4:0]; wdata = d;
      @(posedge clk); #1;
      cs = 0; wr = 0;
   endtask

   task automatic bus_rd(input int a, output logic [31:0] d);
      cs = 1; rd = 1; wr = 0; addr = a[4:0];
      @(posedge clk); #1;
      cs = 0; rd = 0;
      d = readdata;
   endtask

   task automatic pulse_reset();
      #1 reset = 1'b1;
      #1;
      chk("async_rst_duty", duty_cycle, 128'd0);
      chk("async_rst_in", 128'(motor_in), 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   function automatic int pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) return $urandom_range(0, 7);
      if (r < 7) return $urandom_range(8, 15);
      if (r < 9) return $urandom_range(16, 19);
      return $urandom_range(20, 31);
   endfunction

   function automatic int pick_data(input int a);
      if (a < 8) return ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 300);
      if (a < 16) return $urandom_range(0, 3);
      if (a == 16) return $urandom_range(0, 3);
      if (a == 17) return ($urandom_range(0, 9) == 0) ? 65535 : $urandom_range(0, 50);
      if (a == 18) return $urandom_range(0, 30);
      return $urandom;
   endfunction

   int exp29[5] = '{10, 20, 30, 35, 35};
   int exp30d[5] = '{24, 8, 0, 0, 16};
   int exp30i[5] = '{1, 1, 1, 2, 2};

   initial begin
      logic [31:0] d;
      int ok, nchg, t1, t2, v1, v2, prev, cur;

      @(negedge clk);
      chk("reset_duty", duty_cycle, 128'd0);
      chk("reset_in", 128'(motor_in), 128'd0);
      chk("reset_rdata", 128'(readdata), 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      cyc(2);

      // ramp up on motor 0
      bus_wr(17, 10); bus_wr(8, 1); bus_wr(0, 35);
      ok = 0;
      for (int k = 0; k < 10; k++) begin
         if (duty_cycle[15:0] != 16'd0) begin ok = 1; break; end
         cyc(1);
      end
      chk("ramp_start", 128'(ok), 128'd1);
      for (int j = 0; j < 5; j++) begin
         chk("ramp_seq", 128'(duty_cycle[15:0]), 128'(exp29[j]));
         cyc(1);
      end
      bus_rd(19, d); chk("ramp_status", 128'(d), 128'd0);
      bus_rd(0, d);  chk("ramp_rd_duty", 128'(d), 128'd35);
      bus_rd(8, d);  chk("ramp_rd_in", 128'(d), 128'd1);

      // direction swap on motor 2
      bus_wr(17, 16); bus_wr(10, 1); bus_wr(2, 40);
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         if (duty_cycle[47:32] == 16'd40) begin ok = 1; break; end
         cyc(1);
      end
      chk("swap_reach40", 128'(ok), 128'd1);
      bus_wr(10, 2);
      for (int j = 0; j < 5; j++) begin
         cyc(1);
         chk("swap_duty", 128'(duty_cycle[47:32]), 128'(exp30d[j]));
         chk("swap_in", 128'(motor_in[5:4]), 128'(exp30i[j]));
      end

      // prescale on motor 5
      bus_wr(13, 1); cyc(4);
      bus_wr(17, 1); bus_wr(16, 3); bus_wr(5, 2);
      prev = 0; nchg = 0; t1 = 0; t2 = 0; v1 = 0; v2 = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         cur = int'(duty_cycle[95:80]);
         if (cur != prev) begin
            nchg++;
            if (nchg == 1) begin t1 = k; v1 = cur; end
            else if (nchg == 2) begin t2 = k; v2 = cur; end
         end
         prev = cur;
      end
      chk("presc_nchg", 128'(nchg), 128'd2);
      chk("presc_v1", 128'(v1), 128'd1);
      chk("presc_v2", 128'(v2), 128'd2);
      chk("presc_gap", 128'(t2 - t1), 128'd4);

      // async reset mid-ramp
      bus_wr(16, 0); bus_wr(17, 1); bus_wr(0, 1000);
      cyc(5);
      pulse_reset();
      bus_rd(19, d); chk("post_rst_status", 128'(d), 128'd0);
      bus_rd(0, d);  chk("post_rst_duty0", 128'(d), 128'd0);
      bus_rd(17, d); chk("post_rst_step", 128'(d), 128'd0);

      bus_wr(18, 7);
      bus_rd(18, d);
`ifdef MDA_RAMP_WATCHDOG_EN
      chk("wd_timeout_rd", 128'(d), 128'd7);
      bus_wr(18, 0);

      bus_wr(17, 20); bus_wr(8, 1); bus_wr(9, 1); bus_wr(0, 100); bus_wr(1, 100);
      ok = 0;
      for (int k = 0; k < 30; k++) begin
         if (duty_cycle[15:0] == 16'd100 && duty_cycle[31:16] == 16'd100) begin ok = 1; break; end
         cyc(1);
      end
      chk("wd_prep", 128'(ok), 128'd1);
      bus_wr(18, 5);
      ok = 0;
      for (int k = 0; k < 30; k++) begin
         bus_rd(19, d);
         if (d[8]) begin ok = 1; break; end
      end
      chk("wd_trip_set", 128'(ok), 128'd1);
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         if (duty_cycle == 128'd0 && motor_in == 16'd0) begin ok = 1; break; end
         cyc(1);
      end
      chk("wd_all_off", 128'(ok), 128'd1);
      bus_wr(18, 0); bus_wr(19, 0);
      bus_rd(19, d); chk("wd_trip_clr", 128'(d[8]), 128'd0);
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         if (duty_cycle[15:0] == 16'd100 && motor_in[1:0] == 2'd1) begin ok = 1; break; end
         cyc(1);
      end
      chk("wd_resume", 128'(ok), 128'd1);
`else
      chk("wd_timeout_rd", 128'(d), 128'd0);
      bus_wr(19, 32'h1FF);
      bus_rd(19, d); chk("wd_status_idle", 128'(d), 128'd0);
`endif

      for (int n = 0; n < 600; n++) begin
         int op, a, dv;
         if (n == 300) pulse_reset();
         op = $urandom_range(0, 9);
         if (op < 5) begin
            a  = pick_addr();
            dv = pick_data(a);
            cs = 1; wr = 1; rd = 1'($urandom_range(0, 1)); addr = a[4:0]; wdata = dv;
            @(posedge clk); #1;
            cs = 0; wr = 0; rd = 0;
         end else if (op < 7) begin
            bus_rd($urandom_range(0, 31), d);
         end else begin
            cyc($urandom_range(1, 8));
         end
      end
      cyc(50);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
